sd_audio_player: RTL and testbench

//  Downstream consumer of the SD-card sample FIFO. Pops 16-bit PCM words,

---
 rtl/sd_audio_player.sv | 184 ++++++++++++++++++
 tb/tb_sd_audio_player.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_audio_player.sv
// rtl/sd_audio_player.sv - SD sample FIFO to I2S codec player
//
// Purpose: pops 16-bit PCM words from the SD sample FIFO, byte-swaps and
// attenuates them, and serialises them as I2S (BCLK/LRCK/DACDAT). Also
// requests further SD block reads while the FIFO is below the refill level.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   enable           play request; low stops after the current frame
//   vol[2:0]         attenuation (arithmetic right shift), sampled per word
//   fifo_rd_dat[15:0] FIFO word, valid one clk after fifo_rdreq
//   fifo_usedw[10:0] FIFO fill level
//   fifo_rdreq       one-clk pop strobe
//   sd_rd            level request for more SD blocks
//   aud_bclk/aud_lrck/aud_dacdat  I2S to the codec (lrck 0 = left)
//   playing          high in PLAY
//   underrun_cnt[7:0] saturating count of starved fetches
module sd_audio_player #(
  parameter int BCLK_HALF    = 16,
  parameter int START_LEVEL  = 1024,
  parameter int REFILL_LEVEL = 1280,
  parameter bit BYTE_SWAP    = 1'b1,
  parameter bit STEREO       = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  vol,
  input  logic [15:0] fifo_rd_dat,
  input  logic [10:0] fifo_usedw,
  output logic        fifo_rdreq,
  output logic        sd_rd,
  output logic        aud_bclk,
  output logic        aud_lrck,
  output logic        aud_dacdat,
  output logic        playing,
  output logic [7:0]  underrun_cnt
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(BCLK_HALF - 1);
  localparam logic [10:0]      START_LV  = 11'(START_LEVEL);
  localparam logic [10:0]      REFILL_LV = 11'(REFILL_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_PLAY, S_DRAIN} state_t;

  state_t           r_state;
  state_t           w_next;

  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_bit_idx;
  logic [15:0]      r_shift;
  logic [15:0]      r_hold;
  logic             r_lat;
  logic             r_stop;
  logic             r_bclk;
  logic             r_lrck;
  logic             r_dacdat;
  logic             r_rdreq;
  logic             r_sd_rd;
  logic             r_playing;
  logic [7:0]       r_underrun;

  logic             w_tc;
  logic             w_fall;
  logic             w_stop_req;
  logic             w_wrap;
  logic             w_fetch_slot;
  logic             w_usedw_zero;
  logic             w_prime_go;
  logic             w_in_play;
  logic [5:0]       w_bit_nxt;
  logic [15:0]      w_swapped;
  logic [15:0]      w_out;

  assign w_tc         = (r_div == DIV_TC);
  // Fall tick: the clk on which BCLK goes 1->0; everything frame-related steps here.
  assign w_fall       = (r_state == S_PLAY) && w_tc && r_bclk;
  assign w_stop_req   = r_stop || !enable;
  assign w_wrap       = w_fall && (r_bit_idx == 6'd31);
  assign w_usedw_zero = (fifo_usedw == 11'd0);
  // No fetch once a stop is pending: the frame being finished already has its word.
  assign w_fetch_slot = w_fall && !w_stop_req &&
                        ((r_bit_idx == 6'd30) || (STEREO && (r_bit_idx == 6'd14)));
  assign w_bit_nxt    = (r_bit_idx == 6'd31) ? 6'd0 : r_bit_idx + 6'd1;
  assign w_swapped    = BYTE_SWAP ? {fifo_rd_dat[7:0], fifo_rd_dat[15:8]} : fifo_rd_dat;
  assign w_out        = $signed(r_hold) >>> vol;
  assign w_prime_go   = (r_state == S_PRIME) && (w_next == S_PLAY);
  assign w_in_play    = (r_state == S_PLAY) && (w_next == S_PLAY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_next = S_PRIME;
      S_PRIME: begin
        if (!enable) w_next = S_IDLE;
        else if (fifo_usedw >= START_LV) w_next = S_PLAY;
      end
      S_PLAY:  if (w_wrap && w_stop_req) w_next = S_DRAIN;
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div      <= '0;
      r_bit_idx  <= 6'd0;
      r_shift    <= 16'd0;
      r_hold     <= 16'd0;
      r_lat      <= 1'b0;
      r_stop     <= 1'b0;
      r_bclk     <= 1'b0;
      r_lrck     <= 1'b0;
      r_dacdat   <= 1'b0;
      r_rdreq    <= 1'b0;
      r_sd_rd    <= 1'b0;
      r_playing  <= 1'b0;
      r_underrun <= 8'd0;
    end else begin
      r_sd_rd   <= enable && (fifo_usedw < REFILL_LV);
      r_playing <= (w_next == S_PLAY);
      r_rdreq   <= 1'b0;
      // FIFO data arrives one clk after the pop strobe.
      r_lat     <= r_rdreq;
      if (r_lat) r_hold <= w_swapped;
      // Prefetch the first word so it is ready for bit 1 of the first frame.
      if (w_prime_go) r_rdreq <= !w_usedw_zero;

      if (w_in_play) begin
        r_stop <= w_stop_req;
        r_div  <= w_tc ? '0 : r_div + 1'b1;
        if (w_tc) r_bclk <= !r_bclk;
        if (w_fall) begin
          r_bit_idx <= w_bit_nxt;
          r_lrck    <= w_bit_nxt[4];
          // Bits 1 and 17 carry channel MSBs: data trails lrck by one BCLK.
          if (w_bit_nxt[3:0] == 4'd1) begin
            r_dacdat <= w_out[15];
            r_shift  <= {w_out[14:0], 1'b0};
          end else begin
            r_dacdat <= r_shift[15];
            r_shift  <= {r_shift[14:0], 1'b0};
          end
        end
        if (w_fetch_slot) begin
          if (w_usedw_zero) begin
            r_hold <= 16'd0;
            if (r_underrun != 8'hFF) r_underrun <= r_underrun + 8'd1;
          end else begin
            r_rdreq <= 1'b1;
          end
        end
      end else begin
        // Outside steady play the line is quiet and the frame parks at bit 31,
        // so a new PLAY starts with lrck dropping on its first fall tick.
        r_stop    <= 1'b0;
        r_div     <= '0;
        r_bclk    <= 1'b0;
        r_lrck    <= 1'b0;
        r_dacdat  <= 1'b0;
        r_bit_idx <= 6'd31;
        r_shift   <= 16'd0;
      end
    end
  end

  assign fifo_rdreq   = r_rdreq;
  assign sd_rd        = r_sd_rd;
  assign aud_bclk     = r_bclk;
  assign aud_lrck     = r_lrck;
  assign aud_dacdat   = r_dacdat;
  assign playing      = r_playing;
  assign underrun_cnt = r_underrun;

endmodule

// File: tb/tb_sd_audio_player.sv
// tb/tb_sd_audio_player.sv - scoreboard bench for sd_audio_player
module tb_sd_audio_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  vol;
  logic [15:0] fifo_rd_dat;
  logic [10:0] fifo_usedw;
  logic        fifo_rdreq, sd_rd, aud_bclk, aud_lrck, aud_dacdat, playing;
  logic [7:0]  underrun_cnt;

  logic        en_s;
  logic [2:0]  vol_s;
  logic [15:0] rd_dat_s;
  logic [10:0] usedw_s;
  logic        s_rdreq, s_sd_rd, s_bclk, s_lrck, s_dacdat, s_playing;
  logic [7:0]  s_underrun;

  always #5 clk = ~clk;

  sd_audio_player u_dut (
    .clk(clk), .reset(reset), .enable(enable), .vol(vol),
    .fifo_rd_dat(fifo_rd_dat), .fifo_usedw(fifo_usedw),
    .fifo_rdreq(fifo_rdreq), .sd_rd(sd_rd), .aud_bclk(aud_bclk),
    .aud_lrck(aud_lrck), .aud_dacdat(aud_dacdat), .playing(playing),
    .underrun_cnt(underrun_cnt)
  );

  sd_audio_player #(.BCLK_HALF(1)) u_sat (
    .clk(clk), .reset(reset), .enable(en_s), .vol(vol_s),
    .fifo_rd_dat(rd_dat_s), .fifo_usedw(usedw_s),
    .fifo_rdreq(s_rdreq), .sd_rd(s_sd_rd), .aud_bclk(s_bclk),
    .aud_lrck(s_lrck), .aud_dacdat(s_dacdat), .playing(s_playing),
    .underrun_cnt(s_underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int words_seen = 0;
  int rdreq_cnt  = 0;

  logic [15:0] data_q[$];
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] model(input logic [15:0] w, input logic [2:0] v);
    logic signed [15:0] s;
    s = {w[7:0], w[15:8]};
    return s >>> v;
  endfunction

  // FIFO model: registered read data; each pop queues the word expected on L and R.
  logic [15:0] fm_w;
  always @(posedge clk) begin
    if (fifo_rdreq) begin
      fm_w = (data_q.size() != 0) ? data_q.pop_front() : 16'h0000;
      fifo_rd_dat <= fm_w;
      exp_q.push_back(model(fm_w, vol));
      exp_q.push_back(model(fm_w, vol));
      rdreq_cnt++;
    end
  end

  // I2S receiver: a word completes on the first BCLK rise after lrck changes.
  logic        mon_bclk, mon_lrck;
  logic [15:0] mon_sh;
  int          mon_n;
  always @(negedge clk) begin
    if (!playing) begin
      mon_bclk = 1'b0; mon_lrck = 1'b0; mon_sh = 16'h0; mon_n = 0;
    end else begin
      if (aud_bclk && !mon_bclk) begin
        mon_sh = {mon_sh[14:0], aud_dacdat};
        mon_n++;
        if (aud_lrck != mon_lrck) begin
          if (mon_n >= 16) begin
            if (exp_q.size() == 0) chk("sb_empty", {16'h0, mon_sh}, 32'hFFFF_FFFF);
            else chk("word", {16'h0, mon_sh}, {16'h0, exp_q.pop_front()});
            words_seen++;
          end
          mon_n = 0;
        end
        mon_lrck = aud_lrck;
      end
      mon_bclk = aud_bclk;
    end
  end

  task automatic wait_lrck_rise(input string tag);
    logic prev;
    bit   done;
    done = 0;
    @(negedge clk);
    prev = aud_lrck;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (aud_lrck && !prev) done = 1;
      prev = aud_lrck;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_words(input int target, input string tag);
    int k;
    k = 0;
    while (words_seen < target && k < 8000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_words"}, (words_seen >= target), 1);
  endtask

  task automatic wait_playing(input string tag);
    int k;
    k = 0;
    while (!playing && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(tag, playing, 1);
  endtask

  int k;
  int rd0;

  initial begin
    reset = 1'b1; enable = 1'b0; vol = 3'd0; fifo_usedw = 11'd0; fifo_rd_dat = 16'h0;
    en_s = 1'b0; vol_s = 3'd0; rd_dat_s = 16'h0; usedw_s = 11'd0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {fifo_rdreq, sd_rd, aud_bclk, aud_lrck, aud_dacdat, playing}, 0);
    chk("rst_underrun", underrun_cnt, 0);
    reset = 1'b0;

    // Scenario A: priming threshold, byte swap at full scale, sd_rd, stop.
    vol = 3'd0;
    data_q.push_back(16'h3412);
    for (int i = 0; i < 11; i++) data_q.push_back(16'($urandom));
    fifo_usedw = 11'd1023;
    enable = 1'b1;
    repeat (40) @(negedge clk);
    chk("prime_hold", playing, 0);
    chk("prime_no_rdreq", rdreq_cnt, 0);
    fifo_usedw = 11'd1024;
    wait_playing("play_entry");
    k = 0;
    while (!aud_bclk && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("first_half", k, 16);
    wait_words(8, "a");

    fifo_usedw = 11'd1400;
    repeat (2) @(negedge clk);
    chk("sd_rd_1400", sd_rd, 0);
    fifo_usedw = 11'd1279;
    #1 chk("sd_rd_lag", sd_rd, 0);
    @(negedge clk);
    chk("sd_rd_1279", sd_rd, 1);
    fifo_usedw = 11'd1280;
    @(negedge clk);
    chk("sd_rd_1280", sd_rd, 0);

    wait_lrck_rise("stop");
    enable = 1'b0;
    k = 0;
    while (playing && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("stop_latency", k, 512);
    chk("drain_lines", {aud_bclk, aud_lrck, aud_dacdat}, 0);
    repeat (3) @(negedge clk);
    chk("idle_after_stop", {playing, aud_bclk}, 0);
    exp_q.delete();
    data_q.delete();

    // Scenario B: attenuation with sign extension, then starvation.
    vol = 3'd2;
    data_q.push_back(16'h0080);
    data_q.push_back(16'h0100);
    data_q.push_back(16'hFF7F);
    data_q.push_back(16'h0001);
    for (int i = 0; i < 16; i++) data_q.push_back(16'($urandom));
    fifo_usedw = 11'd1500;
    enable = 1'b1;
    wait_playing("play_entry_b");
    wait_words(words_seen + 8, "b");

    k = 0;
    while (!fifo_rdreq && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("rdreq_seen", fifo_rdreq, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) exp_q.push_back(16'h0000);
    fifo_usedw = 11'd0;
    rd0 = rdreq_cnt;
    for (int i = 0; i < 4; i++) wait_lrck_rise("starve");
    fifo_usedw = 11'd1500;
    chk("starve_no_rdreq", rdreq_cnt - rd0, 0);
    chk("underrun_3", underrun_cnt, 3);
    wait_words(words_seen + 10, "after_starve");

    // Asynchronous reset in the middle of a BCLK-high phase.
    k = 0;
    while (!aud_bclk && k < 100) begin
      @(negedge clk);
      k++;
    end
    #2 reset = 1'b1;
    enable = 1'b0;
    #1;
    chk("rst_mid_outs", {fifo_rdreq, sd_rd, aud_bclk, aud_lrck, aud_dacdat, playing}, 0);
    chk("rst_mid_underrun", underrun_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", playing, 0);
    exp_q.delete();
    data_q.delete();

    // Saturation on a fast-BCLK instance: 262 starved frames.
    en_s = 1'b1;
    usedw_s = 11'd2000;
    k = 0;
    while (!s_playing && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("sat_play", s_playing, 1);
    usedw_s = 11'd0;
    repeat (262 * 64) @(negedge clk);
    chk("underrun_sat", s_underrun, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
